// File: rtl/pwm_pkg.sv
// Shared helpers for the pwm_fader slice: index-width helper, channel limit
// and the per-period fade step.
package pwm_pkg;

  localparam int unsigned MAX_CHANNELS = 16;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  // Move cur toward tgt by step without overshooting; step 0 jumps straight to tgt.
  function automatic int unsigned fade_step(input int unsigned cur,
                                            input int unsigned tgt,
                                            input int unsigned step);
    int unsigned diff;
    if (step == 0) return tgt;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff <= step) ? tgt : cur + step;
    end
    diff = cur - tgt;
    return (diff <= step) ? tgt : cur - step;
  endfunction

endpackage

// File: rtl/pwm_fader_ch.sv
// One fader channel: shadow target/step, current duty, applied target,
// per-phase duty latch and the registered PWM compare.
module pwm_fader_ch import pwm_pkg::*; #(
  parameter int unsigned PERIOD = 256,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_duty,
  input  logic [STEP_W-1:0] wr_step,
  input  logic              bnd,
  input  logic [WIDTH-1:0]  phase_nxt,
  output logic              pwm,
  output logic              busy
);

  logic [WIDTH-1:0]  sh_tgt;
  logic [STEP_W-1:0] sh_step;
  logic [WIDTH-1:0]  tgt;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  act;
  logic [WIDTH-1:0]  cur_d;
  logic [WIDTH-1:0]  duty_nxt;

  // Next cur (fade only on the boundary) and the duty used for the next cycle's compare.
  // act holds the duty for the running phase so a new cur only shows from phase 0.
  always_comb begin
    cur_d    = cur;
    duty_nxt = act;
    if (bnd)
      cur_d = WIDTH'(fade_step(32'(cur), 32'(sh_tgt), 32'(sh_step)));
    if (phase_nxt == '0)
      duty_nxt = cur_d;
  end

  // Shadow capture, boundary apply, phase-aligned duty latch and registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_tgt  <= '0;
      sh_step <= '0;
      tgt     <= '0;
      cur     <= '0;
      act     <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_tgt  <= wr_duty;
        sh_step <= wr_step;
      end
      if (bnd)
        tgt <= sh_tgt;
      cur <= cur_d;
      if (phase_nxt == '0)
        act <= cur_d;
      pwm <= (phase_nxt < duty_nxt);
    end
  end

  // Still fading while the current duty differs from the applied target.
  always_comb begin
    busy = (cur != tgt);
  end

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel PWM generator with per-period hardware fading.
// Optional macro PWM_PHASE_STAGGER_EN: offsets channel i's phase by
// i*(PERIOD/CHANNELS) clocks; otherwise all channels share ctr as phase.
module pwm_fader import pwm_pkg::*; #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PERIOD   = 256,
  parameter int unsigned WIDTH    = $clog2(PERIOD),
  parameter int unsigned STEP_W   = WIDTH,
  parameter int unsigned CH_W     = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic [STEP_W-1:0]   wr_step,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] busy,
  output logic                frame
);

  logic [WIDTH-1:0] ctr;
  logic [WIDTH-1:0] ctr_nxt;
  logic             bnd;
  logic [WIDTH-1:0] duty_clamped;

  // Boundary strobe, counter successor, write backpressure and duty clamp.
  always_comb begin
    bnd          = (32'(ctr) == PERIOD - 1);
    ctr_nxt      = bnd ? '0 : ctr + WIDTH'(1);
    wr_ready     = !bnd;
    duty_clamped = (32'(wr_duty) >= PERIOD) ? WIDTH'(PERIOD - 1) : wr_duty;
  end

  // Period counter; frame is registered so it lines up with ctr == PERIOD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr   <= '0;
      frame <= 1'b0;
    end else begin
      ctr   <= ctr_nxt;
      frame <= (32'(ctr_nxt) == PERIOD - 1);
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    logic [WIDTH-1:0] phase_nxt;
    logic             wr_en;

    // Per-channel write select and next-cycle phase (channels see phase one cycle early
    // because their pwm flop registers the compare).
    always_comb begin
      wr_en = wr_valid && wr_ready && (32'(wr_ch) == i);
`ifdef PWM_PHASE_STAGGER_EN
      if (32'(ctr_nxt) >= (i * (PERIOD / CHANNELS)) % PERIOD)
        phase_nxt = WIDTH'(32'(ctr_nxt) - (i * (PERIOD / CHANNELS)) % PERIOD);
      else
        phase_nxt = WIDTH'(32'(ctr_nxt) + PERIOD - (i * (PERIOD / CHANNELS)) % PERIOD);
`else
      phase_nxt = ctr_nxt;
`endif
    end

    pwm_fader_ch #(
      .PERIOD (PERIOD),
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_duty   (duty_clamped),
      .wr_step   (wr_step),
      .bnd       (bnd),
      .phase_nxt (phase_nxt),
      .pwm       (pwm[i]),
      .busy      (busy[i])
    );
  end

endmodule
